// File: rtl/issue_warp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_warp_arbiter_if
// Brief    : Decode-side enqueue and issue-side output handshake bundle.
// Revision : 1.0
// ============================================================================
interface issue_warp_arbiter_if #(
    parameter int NUM_WARPS  = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int WID_W = $clog2(NUM_WARPS);

    logic                  in_valid;
    logic [WID_W-1:0]      in_wid;
    logic                  in_fence;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    logic                  out_valid;
    logic [WID_W-1:0]      out_wid;
    logic                  out_fence;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output in_valid, in_wid, in_fence, in_data, out_ready,
        input  in_ready, out_valid, out_wid, out_fence, out_data
    );

    modport slave (
        input  in_valid, in_wid, in_fence, in_data, out_ready,
        output in_ready, out_valid, out_wid, out_fence, out_data
    );
endinterface
`default_nettype wire

// File: rtl/issue_warp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : issue_warp_arbiter
// Brief    : Per-warp instruction queues with round-robin issue into a
//            registered output stage, per-warp flush and a store-fence gate.
// Revision : 1.0
// ============================================================================
module issue_warp_arbiter #(
    parameter  int NUM_WARPS  = 4,
    parameter  int DEPTH      = 4,
    parameter  int DATA_WIDTH = 64,
    localparam int WID_W      = $clog2(NUM_WARPS),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    issue_warp_arbiter_if.slave        bus,
    input  logic [NUM_WARPS-1:0]       warp_ready,
    input  logic                       no_pending_stores,
    input  logic                       flush_valid,
    input  logic [WID_W-1:0]           flush_wid,
    output logic [NUM_WARPS*CNT_W-1:0] warp_count,
    output logic [31:0]                perf_stall_cycles
);
    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    // Each entry stores {fence, payload}
    logic [DATA_WIDTH:0]   r_mem    [NUM_WARPS][DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr [NUM_WARPS];
    logic [c_PTR_W-1:0]    r_wr_ptr [NUM_WARPS];
    logic [CNT_W-1:0]      r_count  [NUM_WARPS];
    logic [WID_W-1:0]      r_rr;
    logic                  r_out_valid;
    logic [WID_W-1:0]      r_out_wid;
    logic                  r_out_fence;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [31:0]           r_perf;

    logic                  w_fire;
    logic                  w_load_en;
    logic                  w_found;
    logic                  w_grant_valid;
    logic [WID_W-1:0]      w_grant;
    logic [DATA_WIDTH:0]   w_head_entry;
    logic [NUM_WARPS-1:0]  w_nonempty;
    logic [NUM_WARPS-1:0]  w_head_fence;
    logic [NUM_WARPS-1:0]  w_flush_hit;
    logic [NUM_WARPS-1:0]  w_eligible;
    logic [NUM_WARPS-1:0]  w_push;
    logic [NUM_WARPS-1:0]  w_pop;

    // Uses the registered count, so a full queue refuses even while popping
    assign bus.in_ready = (r_count[bus.in_wid] < c_DEPTH) &&
                          !(flush_valid && (flush_wid == bus.in_wid));
    assign w_fire       = bus.in_valid && bus.in_ready;
    assign w_load_en    = !r_out_valid || bus.out_ready;

    generate
        for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
            assign w_nonempty[w]   = (r_count[w] != '0);
            assign w_head_fence[w] = r_mem[w][r_rd_ptr[w]][DATA_WIDTH];
            assign w_flush_hit[w]  = flush_valid && (flush_wid == WID_W'(w));
            assign w_eligible[w]   = w_nonempty[w] && warp_ready[w] &&
                                     (!w_head_fence[w] || no_pending_stores) &&
                                     !w_flush_hit[w];
            assign w_push[w]       = w_fire && (bus.in_wid == WID_W'(w));
            assign w_pop[w]        = w_grant_valid && (w_grant == WID_W'(w));
            assign warp_count[w*CNT_W +: CNT_W] = r_count[w];
        end
    endgenerate

    always_comb begin : p_grant
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (int'(r_rr) + i) % NUM_WARPS;
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_grant = WID_W'(idx);
            end
        end
    end

    assign w_grant_valid = w_load_en && w_found;
    assign w_head_entry  = r_mem[w_grant][r_rd_ptr[w_grant]];

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_mem[bus.in_wid][r_wr_ptr[bus.in_wid]] <= {bus.in_fence, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_rd_ptr[w] <= '0;
                r_wr_ptr[w] <= '0;
                r_count[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (w_flush_hit[w]) begin
                    r_rd_ptr[w] <= r_wr_ptr[w];
                    r_count[w]  <= '0;
                end else begin
                    if (w_push[w]) r_wr_ptr[w] <= r_wr_ptr[w] + 1'b1;
                    if (w_pop[w])  r_rd_ptr[w] <= r_rd_ptr[w] + 1'b1;
                    if (w_push[w] && !w_pop[w]) begin
                        r_count[w] <= r_count[w] + 1'b1;
                    end else if (!w_push[w] && w_pop[w]) begin
                        r_count[w] <= r_count[w] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_wid   <= '0;
            r_out_fence <= 1'b0;
            r_out_data  <= '0;
            r_rr        <= '0;
            r_perf      <= '0;
        end else begin
            if (w_load_en) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_wid   <= w_grant;
                    r_out_fence <= w_head_entry[DATA_WIDTH];
                    r_out_data  <= w_head_entry[DATA_WIDTH-1:0];
                end
            end
            if (w_grant_valid) begin
                r_rr <= (w_grant == WID_W'(NUM_WARPS - 1)) ? '0 : w_grant + 1'b1;
            end
            if ((|w_nonempty) && w_load_en && !w_found && (r_perf != 32'hFFFF_FFFF)) begin
                r_perf <= r_perf + 32'd1;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_wid       = r_out_wid;
    assign bus.out_fence     = r_out_fence;
    assign bus.out_data      = r_out_data;
    assign perf_stall_cycles = r_perf;
endmodule
`default_nettype wire

// File: tb/tb_issue_warp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_warp_arbiter
// Brief    : Directed self-checking bench for issue_warp_arbiter (4 warps x 4).
// Revision : 1.0
// ============================================================================
module tb_issue_warp_arbiter;
    localparam int NW = 4;
    localparam int DW = 64;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NW-1:0] warp_ready;
    logic          no_pending_stores;
    logic          flush_valid;
    logic [1:0]    flush_wid;
    logic [NW*CW-1:0] warp_count;
    logic [31:0]   perf_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    issue_warp_arbiter_if #(.NUM_WARPS(NW), .DATA_WIDTH(DW)) bus ();

    issue_warp_arbiter #(.NUM_WARPS(NW), .DEPTH(4), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus               (bus),
        .warp_ready        (warp_ready),
        .no_pending_stores (no_pending_stores),
        .flush_valid       (flush_valid),
        .flush_wid         (flush_wid),
        .warp_count        (warp_count),
        .perf_stall_cycles (perf_stall_cycles)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int w);
        return warp_count[w*CW +: CW];
    endfunction

    task automatic drive_in(input logic v, input logic [1:0] wid, input logic f, input logic [63:0] d);
        bus.in_valid = v;
        bus.in_wid   = wid;
        bus.in_fence = f;
        bus.in_data  = d;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] wid,
                             input logic f, input logic [63:0] d);
        check_eq({tag, "_valid"}, bus.out_valid, v);
        if (v) begin
            check_eq({tag, "_wid"},   bus.out_wid,   wid);
            check_eq({tag, "_fence"}, bus.out_fence, f);
            check_eq({tag, "_data"},  bus.out_data,  d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        warp_ready        = 4'hF;
        no_pending_stores = 1'b1;
        flush_valid       = 1'b0;
        flush_wid         = 2'd0;
        bus.out_ready     = 1'b1;
        drive_in(1'b0, 2'd0, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_data", bus.out_data, 64'd0);
        check_eq("rst_counts", warp_count, 12'd0);
        check_eq("rst_perf", perf_stall_cycles, 32'd0);
        reset_n = 1'b1;

        // Single entry: accept at N, visible on the output at N+2
        @(negedge clk);
        drive_in(1'b1, 2'd2, 1'b0, 64'hA5);
        #1 check_eq("t1_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        drive_in(1'b0, 2'd0, 1'b0, 64'd0);
        check_eq("t1_early_valid", bus.out_valid, 1'b0);
        check_eq("t1_cnt2_1", cnt(2), 3'd1);
        @(negedge clk);
        check_out("t1_out", 1'b1, 2'd2, 1'b0, 64'hA5);
        check_eq("t1_cnt2_0", cnt(2), 3'd0);
        @(negedge clk);
        check_eq("t1_idle", bus.out_valid, 1'b0);

        // Burst of two entries per warp, released together
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_in(1'b1, 2'(i % 4), 1'b0, 64'h100 + 64'(i));
            @(negedge clk);
        end
        drive_in(1'b0, 2'd0, 1'b0, 64'd0);
        check_eq("t2_cnt0", cnt(0), 3'd1);
        check_eq("t2_cnt3", cnt(3), 3'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_out("t2_issue", 1'b1, 2'(k % 4), 1'b0, 64'h100 + 64'(k));
            @(negedge clk);
        end
        check_eq("t2_drained", bus.out_valid, 1'b0);
        check_eq("t2_perf", perf_stall_cycles, 32'd0);

        // Fill warp 1 behind a held output, then stream across pointer wrap
        bus.out_ready = 1'b0;
        drive_in(1'b1, 2'd0, 1'b0, 64'h1FF);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            drive_in(1'b1, 2'd1, 1'b0, 64'h200 + 64'(j));
        end
        @(negedge clk);
        drive_in(1'b0, 2'd1, 1'b0, 64'd0);
        #1 check_eq("t3_full_w1", bus.in_ready, 1'b0);
        bus.in_wid = 2'd0;
        #1 check_eq("t3_ready_w0", bus.in_ready, 1'b1);
        check_eq("t3_cnt1", cnt(1), 3'd4);
        check_out("t3_held", 1'b1, 2'd0, 1'b0, 64'h1FF);
        bus.out_ready = 1'b1;
        fork
            begin
                for (int v = 4; v < 10; v++) begin
                    int t;
                    t = 0;
                    drive_in(1'b1, 2'd1, 1'b0, 64'h200 + 64'(v));
                    #1;
                    while (!bus.in_ready && t < 20) begin
                        @(negedge clk);
                        #1;
                        t++;
                    end
                    check_eq("t3_enq_wait", bus.in_ready, 1'b1);
                    @(negedge clk);
                end
                drive_in(1'b0, 2'd0, 1'b0, 64'd0);
            end
            begin
                int idx;
                idx = 0;
                for (int c = 0; c < 30; c++) begin
                    if (bus.out_valid) begin
                        check_eq("t3_order", bus.out_data,
                                 (idx == 0) ? 64'h1FF : 64'h200 + 64'(idx - 1));
                        idx++;
                    end
                    @(negedge clk);
                end
                check_eq("t3_issued", idx, 11);
            end
        join
        check_eq("t3_counts", warp_count, 12'd0);
        check_eq("t3_perf", perf_stall_cycles, 32'd0);

        // Fence head on warp 0 waits for stores; warp 1 is unaffected
        no_pending_stores = 1'b0;
        drive_in(1'b1, 2'd1, 1'b0, 64'h301);
        @(negedge clk);
        drive_in(1'b1, 2'd0, 1'b1, 64'h300);
        check_eq("t4_e1_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        drive_in(1'b0, 2'd0, 1'b0, 64'd0);
        check_out("t4_w1", 1'b1, 2'd1, 1'b0, 64'h301);
        check_eq("t4_perf0", perf_stall_cycles, 32'd0);
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            check_eq("t4_blocked", bus.out_valid, 1'b0);
            check_eq("t4_perf_inc", perf_stall_cycles, 32'(s));
        end
        no_pending_stores = 1'b1;
        @(negedge clk);
        check_out("t4_fence", 1'b1, 2'd0, 1'b1, 64'h300);
        check_eq("t4_perf_hold", perf_stall_cycles, 32'd3);
        @(negedge clk);
        check_eq("t4_idle", bus.out_valid, 1'b0);

        // Flush warp 3 while warp 2's entry sits in the output register
        bus.out_ready = 1'b0;
        drive_in(1'b1, 2'd2, 1'b0, 64'h400);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            drive_in(1'b1, 2'd3, 1'b0, 64'h400 + 64'(j));
        end
        @(negedge clk);
        drive_in(1'b1, 2'd3, 1'b0, 64'h4FF);
        flush_valid   = 1'b1;
        flush_wid     = 2'd3;
        bus.out_ready = 1'b1;
        #1 check_eq("t5_in_ready", bus.in_ready, 1'b0);
        check_eq("t5_cnt3_pre", cnt(3), 3'd3);
        check_out("t5_held", 1'b1, 2'd2, 1'b0, 64'h400);
        @(negedge clk);
        flush_valid = 1'b0;
        drive_in(1'b0, 2'd0, 1'b0, 64'd0);
        check_eq("t5_cnt3_post", cnt(3), 3'd0);
        check_eq("t5_no_issue0", bus.out_valid, 1'b0);
        check_eq("t5_perf", perf_stall_cycles, 32'd4);
        repeat (3) begin
            @(negedge clk);
            check_eq("t5_no_issue", bus.out_valid, 1'b0);
        end
        check_eq("t5_perf_hold", perf_stall_cycles, 32'd4);

        // Asynchronous reset with work in flight
        bus.out_ready = 1'b0;
        drive_in(1'b1, 2'd0, 1'b0, 64'h500);
        @(negedge clk);
        drive_in(1'b1, 2'd1, 1'b0, 64'h501);
        @(negedge clk);
        drive_in(1'b1, 2'd1, 1'b0, 64'h502);
        @(negedge clk);
        drive_in(1'b0, 2'd0, 1'b0, 64'd0);
        check_eq("t6_pre_valid", bus.out_valid, 1'b1);
        check_eq("t6_pre_cnt1", cnt(1), 3'd2);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_async_valid", bus.out_valid, 1'b0);
        check_eq("t6_async_data", bus.out_data, 64'd0);
        check_eq("t6_async_counts", warp_count, 12'd0);
        check_eq("t6_async_perf", perf_stall_cycles, 32'd0);
        repeat (2) @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("t6_no_pulse", bus.out_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/issue_warp_arbiter.md
Name: issue_warp_arbiter

Overview:
- Parametrised successor to the single-slice issue front end: per-warp instruction queues of configurable count and depth.
- Round-robin selection of one eligible warp head per cycle into a registered output stage.
- Per-warp flush.
- Memory-ordering gate: fence/atomic heads issue only while no_pending_stores is high.
- Sits between decode and operand collection; replaces the fixed ibuffer-plus-select path.

Parameters:
- NUM_WARPS, 4, number of per-warp queues (>=2)
- DEPTH, 4, entries per warp queue (power of 2, >=2)
- DATA_WIDTH, 64, opaque instruction payload width
- WID_W, clog2(NUM_WARPS), derived warp-id width
- CNT_W, clog2(DEPTH)+1, derived per-queue count width

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode entry valid
- in_wid  input  WID_W  destination warp queue
- in_fence  input  1  entry requires no pending stores before issue
- in_data  input  DATA_WIDTH  instruction payload
- in_ready  output  1  entry accepted when in_valid && in_ready
- warp_ready  input  NUM_WARPS  per-warp scoreboard clear for current head
- no_pending_stores  input  1  LSU reports zero outstanding stores
- flush_valid  input  1  discard all queued entries of flush_wid
- flush_wid  input  WID_W  warp to flush
- out_valid  output  1  issued entry valid
- out_wid  output  WID_W  warp of issued entry
- out_fence  output  1  fence flag of issued entry
- out_data  output  DATA_WIDTH  issued payload
- out_ready  input  1  downstream accept
- warp_count  output  NUM_WARPS*CNT_W  per-warp occupancy, warp w at bits [w*CNT_W +: CNT_W]
- perf_stall_cycles  output  32  count of cycles with >=1 non-empty queue and no eligible head

Behaviour:
- Reset (reset_n low, async): all queues empty, rr pointer 0, out_valid 0, out_wid/out_fence/out_data 0, perf_stall_cycles 0, warp_count all 0.
- Handshakes:
  - in_ready = (warp_count[in_wid] < DEPTH) && !(flush_valid && flush_wid == in_wid).
  - Combinational in in_wid and flush inputs only; independent of in_valid.
- Enqueue: on fire, write the tail of queue in_wid; visible as head next cycle.
  - No bypass: minimum latency enqueue to out_valid is 2 cycles (cycle N accept, N+1 arbitrate/load, out_valid high at N+2).
- Eligibility of warp w: queue non-empty && warp_ready[w] && (!head_fence[w] || no_pending_stores) && !(flush_valid && flush_wid == w).
- Output register load enable = !out_valid || out_ready.
  - When enabled and any warp is eligible, grant one warp, pop its head, load the output register, set out_valid=1.
  - When enabled and none is eligible, out_valid goes 0.
  - When not enabled, the register holds and nothing pops.
- Round-robin:
  - Search order starts at rr pointer, increasing and wrapping modulo NUM_WARPS.
  - After a grant to warp g, rr pointer = (g+1) mod NUM_WARPS.
  - Pointer is unchanged when no grant occurs.
- Same-warp enqueue and pop in one cycle: count unchanged, both pointers advance. A full queue is not accepted even if popping that cycle (in_ready uses registered count).
- Flush:
  - Queue flush_wid becomes empty next cycle (head = tail, count 0).
  - Any enqueue to that warp is blocked (in_ready 0).
  - That warp cannot be granted in the same cycle.
  - An entry already in the output register is unaffected.
  - Flushing an empty queue is a no-op.
- Fence:
  - A fence head with no_pending_stores=0 blocks only its own warp; other warps keep issuing.
  - no_pending_stores is sampled combinationally in the grant cycle.
- Pointer wrap: queue read/write pointers wrap modulo DEPTH.
- perf_stall_cycles:
  - Increments when any queue is non-empty, load enable is 1, and no warp is eligible.
  - Saturates at 2^32-1.
- Reset asserted mid-operation: queued and in-flight entries are discarded immediately; no out_valid pulse on reset release.

Test Plan:
- Reset then 1 entry to warp 2 (data 0xA5), warp_ready all 1, out_ready 1 -> out_valid high 2 cycles after accept, out_wid=2, out_data=0xA5, warp_count[2] back to 0.
- 2 entries each to warps 0..3 in one burst, all ready, out_ready 1 -> issue order wid 0,1,2,3,0,1,2,3 with no idle cycles between grants.
- Fill warp 1 with DEPTH=4 entries, out_ready 0 -> in_ready 0 for in_wid=1 and 1 for in_wid=0. Release out_ready -> FIFO order preserved across pointer wrap after 6 more enqueues.
- Fence head on warp 0, normal head on warp 1, no_pending_stores 0 for 5 cycles -> only warp 1 issues. perf_stall_cycles increments each cycle once warp 1 drains. After no_pending_stores rises, warp 0 issues with out_fence=1.
- Warp 3 holding 3 entries; flush_valid with flush_wid=3 plus simultaneous in_valid to warp 3 -> in_ready 0, warp_count[3]=0 next cycle, no warp-3 issue afterward. Entry already in the output register still completes.
- Assert reset_n low while out_valid=1 and queues non-empty -> out_valid 0 immediately (async), all counts 0, perf_stall_cycles 0.
